// File: rtl/stream_deinterleaver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_deinterleaver_pkg
// Purpose  : Shared defaults and width helpers for the stream deinterleaver
//            (lane index width, total count width, lane pointer width).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package stream_deinterleaver_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_LANES  = 2;
  localparam int DEF_LANE_DEPTH = 2;

  // Width of the next-lane index; kept at least one bit wide.
  function automatic int lane_idx_width(input int num_lanes);
    return (num_lanes > 1) ? $clog2(num_lanes) : 1;
  endfunction

  // Width able to hold 0..num_lanes*lane_depth inclusive.
  function automatic int count_width(input int num_lanes, input int lane_depth);
    return $clog2(num_lanes * lane_depth) + 1;
  endfunction

  // Lane pointer: index bits plus one wrap bit for full/empty detection.
  function automatic int ptr_width(input int lane_depth);
    return $clog2(lane_depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_deinterleaver_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_deinterleaver_if
// Purpose  : Bundles the input stream, the per-lane output streams, the flush
//            and the status outputs of the stream deinterleaver.
// Signals  : in_data/in_valid/in_ready - single interleaved input stream
//            out_data/out_valid/out_ready - NUM_LANES lane streams, lane i
//                                           data at [i*DATA_WIDTH +: DATA_WIDTH]
//            clear     - synchronous flush
//            next_lane - lane receiving the next accepted word
//            count     - total words buffered over all lanes
// Modports : master (producer + lane consumers), slave (deinterleaver)
// Revision : 1.0 - initial release
// ============================================================================
interface stream_deinterleaver_if
  import stream_deinterleaver_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_LANES  = DEF_NUM_LANES,
  parameter int LANE_DEPTH = DEF_LANE_DEPTH
) ();

  logic [DATA_WIDTH-1:0]                           in_data;
  logic                                            in_valid;
  logic                                            in_ready;
  logic [NUM_LANES*DATA_WIDTH-1:0]                 out_data;
  logic [NUM_LANES-1:0]                            out_valid;
  logic [NUM_LANES-1:0]                            out_ready;
  logic                                            clear;
  logic [lane_idx_width(NUM_LANES)-1:0]            next_lane;
  logic [count_width(NUM_LANES, LANE_DEPTH)-1:0]   count;

  modport master (
    output in_data, in_valid, out_ready, clear,
    input  in_ready, out_data, out_valid, next_lane, count
  );

  modport slave (
    input  in_data, in_valid, out_ready, clear,
    output in_ready, out_data, out_valid, next_lane, count
  );

endinterface
`default_nettype wire

// File: rtl/deint_lane_fifo.sv
`default_nettype none
// ============================================================================
// Module   : deint_lane_fifo
// Purpose  : Small synchronous FIFO holding the words of one output lane.
// Ports    : clk, rstn (async active-low)
//            clear     - flush to empty, wins over push/pop
//            push/wr_data - write request (ignored when full)
//            pop       - read request (ignored when empty)
//            rd_data   - head word (stale when empty)
//            full, empty, occupancy - status
// Revision : 1.0 - initial release
// ============================================================================
module deint_lane_fifo
  import stream_deinterleaver_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANE_DEPTH = DEF_LANE_DEPTH
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               clear,
  input  logic                               push,
  input  logic                               pop,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  output logic [DATA_WIDTH-1:0]              rd_data,
  output logic                               full,
  output logic                               empty,
  output logic [ptr_width(LANE_DEPTH)-1:0]   occupancy
);

  localparam int PW = ptr_width(LANE_DEPTH);
  localparam int IW = PW - 1;

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] mem [LANE_DEPTH];
  logic                  do_push;
  logic                  do_pop;

  // Same slot index with opposite wrap bits means the writer lapped the reader.
  assign full      = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[IW] != rd_ptr[IW]);
  assign empty     = (wr_ptr == rd_ptr);
  assign occupancy = wr_ptr - rd_ptr;
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign rd_data   = mem[rd_ptr[IW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < LANE_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[IW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_deinterleaver.sv
`default_nettype none
// ============================================================================
// Module   : stream_deinterleaver
// Purpose  : Splits one valid/ready stream into NUM_LANES lane streams in
//            strict round-robin order (word k -> lane k mod NUM_LANES), each
//            lane buffered in its own small FIFO.
// Ports    : clk  - clock
//            rstn - asynchronous active-low reset
//            bus  - stream_deinterleaver_if.slave (input stream, lane
//                   streams, clear, next_lane, count)
// Revision : 1.0 - initial release
// ============================================================================
module stream_deinterleaver
  import stream_deinterleaver_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_LANES  = DEF_NUM_LANES,
  parameter int LANE_DEPTH = DEF_LANE_DEPTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  stream_deinterleaver_if.slave bus
);

  localparam int             LW        = lane_idx_width(NUM_LANES);
  localparam int             CW        = count_width(NUM_LANES, LANE_DEPTH);
  localparam int             PW        = ptr_width(LANE_DEPTH);
  localparam logic [LW-1:0]  LAST_LANE = LW'(NUM_LANES - 1);

  logic [LW-1:0]                   next_lane;
  logic [NUM_LANES-1:0]            lane_full;
  logic [NUM_LANES-1:0]            lane_empty;
  logic [NUM_LANES-1:0]            lane_push;
  logic [NUM_LANES-1:0]            lane_pop;
  logic [PW-1:0]                   lane_occ [NUM_LANES];
  logic [NUM_LANES*DATA_WIDTH-1:0] lane_data;
  logic [CW-1:0]                   total;
  logic                            accept;

  // Only the target lane gates the input, so a full lane stalls the stream
  // even when others have room; this keeps the round-robin order intact.
  assign bus.in_ready  = !lane_full[next_lane];
  assign accept        = bus.in_valid && bus.in_ready && !bus.clear;
  assign lane_pop      = bus.out_valid & bus.out_ready;
  assign bus.out_valid = ~lane_empty;
  assign bus.out_data  = lane_data;
  assign bus.next_lane = next_lane;
  assign bus.count     = total;

  always_comb begin
    lane_push = '0;
    if (accept) begin
      lane_push[next_lane] = 1'b1;
    end
  end

  // Total occupancy is the sum of the registered lane occupancies, so it
  // moves on the same edge as the pushes and pops that change it.
  always_comb begin
    total = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      total = total + CW'(lane_occ[i]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      next_lane <= '0;
    end else if (bus.clear) begin
      next_lane <= '0;
    end else if (accept) begin
      next_lane <= (next_lane == LAST_LANE) ? '0 : next_lane + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    deint_lane_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANE_DEPTH (LANE_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .clear     (bus.clear),
      .push      (lane_push[i]),
      .pop       (lane_pop[i]),
      .wr_data   (bus.in_data),
      .rd_data   (lane_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .full      (lane_full[i]),
      .empty     (lane_empty[i]),
      .occupancy (lane_occ[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_deinterleaver.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_deinterleaver
// Purpose  : Self-checking bench for stream_deinterleaver. Two instances
//            (NUM_LANES=2 and 4) share one clock/reset. A monitor keeps one
//            queue of expected words per lane and compares every cycle;
//            directed sequences run on the 2-lane instance, then random
//            traffic runs on both.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_deinterleaver;
  import stream_deinterleaver_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 2;
  localparam int NCFG  = 2;
  localparam int MAXL  = 4;
  localparam int OW    = MAXL * DW;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0]   in_data   [NCFG];
  logic            in_valid  [NCFG];
  logic            in_ready  [NCFG];
  logic            clear     [NCFG];
  logic [OW-1:0]   out_data  [NCFG];
  logic [MAXL-1:0] out_valid [NCFG];
  logic [MAXL-1:0] out_ready [NCFG];
  logic [1:0]      next_lane [NCFG];
  logic [3:0]      count     [NCFG];

  // Reference model: expected words per lane in arrival order plus the
  // lane the next accepted word belongs to.
  logic [DW-1:0] exp_q      [NCFG][MAXL][$];
  int            model_next [NCFG];

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int NL = (g == 0) ? 2 : 4;

    stream_deinterleaver_if #(
      .DATA_WIDTH (DW),
      .NUM_LANES  (NL),
      .LANE_DEPTH (DEPTH)
    ) bus ();

    stream_deinterleaver #(
      .DATA_WIDTH (DW),
      .NUM_LANES  (NL),
      .LANE_DEPTH (DEPTH)
    ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
    );

    assign bus.in_data   = in_data[g];
    assign bus.in_valid  = in_valid[g];
    assign bus.clear     = clear[g];
    assign bus.out_ready = out_ready[g][NL-1:0];
    assign in_ready[g]   = bus.in_ready;
    assign out_data[g]   = OW'(bus.out_data);
    assign out_valid[g]  = MAXL'(bus.out_valid);
    assign next_lane[g]  = 2'(bus.next_lane);
    assign count[g]      = 4'(bus.count);
  end

  function automatic int lanes_of(input int c);
    return (c == 0) ? 2 : 4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] lane_word(input int c, input int l);
    return out_data[c][l*DW +: DW];
  endfunction

  // One cycle of the model, evaluated just before the rising edge.
  task automatic model_step(input int c);
    int  nl;
    int  total;
    bit  exp_ready;
    nl = lanes_of(c);
    if (!rstn) begin
      for (int l = 0; l < MAXL; l++) exp_q[c][l].delete();
      model_next[c] = 0;
      return;
    end
    total = 0;
    for (int l = 0; l < nl; l++) total += exp_q[c][l].size();
    exp_ready = (exp_q[c][model_next[c]].size() < DEPTH);
    check($sformatf("cfg%0d count", c), 32'(count[c]), 32'(total));
    check($sformatf("cfg%0d next_lane", c), 32'(next_lane[c]), 32'(model_next[c]));
    check($sformatf("cfg%0d in_ready", c), 32'(in_ready[c]), 32'(exp_ready));
    for (int l = 0; l < nl; l++) begin
      check($sformatf("cfg%0d lane%0d out_valid", c, l), 32'(out_valid[c][l]),
            32'(exp_q[c][l].size() > 0));
      if (exp_q[c][l].size() > 0)
        check($sformatf("cfg%0d lane%0d out_data", c, l), 32'(lane_word(c, l)),
              32'(exp_q[c][l][0]));
    end
    // Effects of the coming edge, derived from the model's own view.
    if (clear[c]) begin
      for (int l = 0; l < MAXL; l++) exp_q[c][l].delete();
      model_next[c] = 0;
    end else begin
      for (int l = 0; l < nl; l++)
        if (out_ready[c][l] && exp_q[c][l].size() > 0) void'(exp_q[c][l].pop_front());
      if (in_valid[c] && exp_ready) begin
        exp_q[c][model_next[c]].push_back(in_data[c]);
        model_next[c] = (model_next[c] + 1) % nl;
      end
    end
  endtask

  always begin
    @(negedge clk);
    #4;
    for (int c = 0; c < NCFG; c++) model_step(c);
  end

  task automatic run_random(input int c, input int nwords);
    int sent   = 0;
    int cycles = 0;
    int pr;
    bit pending = 1'b0;
    while (sent < nwords && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      if (!pending && $urandom_range(0, 3) != 0) begin
        in_data[c] = DW'($urandom);
        pending    = 1'b1;
      end
      in_valid[c] = pending;
      pr = ((cycles / 100) % 2 == 1) ? 20 : 75;
      for (int l = 0; l < MAXL; l++) out_ready[c][l] = ($urandom_range(0, 99) < pr);
      #4;
      if (pending && in_ready[c]) begin
        pending = 1'b0;
        sent++;
      end
    end
    @(negedge clk);
    in_valid[c] = 1'b0;
    check($sformatf("cfg%0d random words sent", c), 32'(sent), 32'(nwords));
    out_ready[c] = '1;
    repeat (12) @(negedge clk);
    check($sformatf("cfg%0d drained count", c), 32'(count[c]), 32'd0);
    check($sformatf("cfg%0d drained out_valid", c), 32'(out_valid[c]), 32'd0);
  endtask

  task automatic reset_values(input string tag);
    check({tag, " in_ready"}, 32'(in_ready[0]), 32'd1);
    check({tag, " out_valid"}, 32'(out_valid[0]), 32'd0);
    check({tag, " count"}, 32'(count[0]), 32'd0);
    check({tag, " next_lane"}, 32'(next_lane[0]), 32'd0);
    check({tag, " out_data"}, 32'(out_data[0]), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] words [4];
    words = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int c = 0; c < NCFG; c++) begin
      in_data[c]   = '0;
      in_valid[c]  = 1'b0;
      clear[c]     = 1'b0;
      out_ready[c] = '0;
      model_next[c] = 0;
    end

    // Reset held for ten cycles.
    repeat (10) @(negedge clk);
    reset_values("reset");
    rstn = 1'b1;

    // Fill both lanes with no consumer activity.
    for (int k = 0; k < 4; k++) begin
      in_data[0]  = words[k];
      in_valid[0] = 1'b1;
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    check("fill lane0 head", 32'(lane_word(0, 0)), 32'h11);
    check("fill lane1 head", 32'(lane_word(0, 1)), 32'h22);
    check("fill count", 32'(count[0]), 32'd4);
    check("fill next_lane", 32'(next_lane[0]), 32'd0);
    check("fill in_ready", 32'(in_ready[0]), 32'd0);

    // Popping the other lane must not release the stalled input.
    in_data[0]   = 8'h55;
    in_valid[0]  = 1'b1;
    out_ready[0] = 4'b0010;
    @(negedge clk);
    check("stall in_ready", 32'(in_ready[0]), 32'd0);
    check("stall lane1 head", 32'(lane_word(0, 1)), 32'h44);
    check("stall count", 32'(count[0]), 32'd3);
    out_ready[0] = 4'b0001;
    @(negedge clk);
    out_ready[0] = 4'b0000;
    check("unstall lane0 head", 32'(lane_word(0, 0)), 32'h33);
    check("unstall in_ready", 32'(in_ready[0]), 32'd1);
    @(negedge clk);
    in_valid[0] = 1'b0;
    check("accept 0x55 count", 32'(count[0]), 32'd3);
    check("accept 0x55 next_lane", 32'(next_lane[0]), 32'd1);

    // Push to lane1 while both lanes pop.
    in_data[0]   = 8'h66;
    in_valid[0]  = 1'b1;
    out_ready[0] = 4'b0011;
    @(negedge clk);
    check("dual pop lane0 head", 32'(lane_word(0, 0)), 32'h55);
    check("dual pop lane1 head", 32'(lane_word(0, 1)), 32'h66);
    check("dual pop count", 32'(count[0]), 32'd2);

    // Same-lane push and pop on a one-word lane.
    in_data[0]   = 8'h77;
    out_ready[0] = 4'b0001;
    @(negedge clk);
    check("push+pop count", 32'(count[0]), 32'd2);
    check("push+pop lane0 head", 32'(lane_word(0, 0)), 32'h77);
    check("push+pop out_valid", 32'(out_valid[0]), 32'b11);
    in_data[0]   = 8'hAA;
    out_ready[0] = 4'b0000;
    @(negedge clk);
    in_valid[0] = 1'b0;
    check("pre-clear count", 32'(count[0]), 32'd3);

    // Flush with a word presented; the word is dropped.
    in_data[0]  = 8'h88;
    in_valid[0] = 1'b1;
    clear[0]    = 1'b1;
    #1;
    check("clear in_ready", 32'(in_ready[0]), 32'd1);
    @(negedge clk);
    clear[0]    = 1'b0;
    in_valid[0] = 1'b0;
    check("clear count", 32'(count[0]), 32'd0);
    check("clear out_valid", 32'(out_valid[0]), 32'd0);
    check("clear next_lane", 32'(next_lane[0]), 32'd0);
    in_data[0]  = 8'h99;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_data[0]  = 8'hBB;
    check("post-clear out_valid", 32'(out_valid[0]), 32'b01);
    check("post-clear lane0 head", 32'(lane_word(0, 0)), 32'h99);
    @(negedge clk);
    in_valid[0] = 1'b0;

    // Asynchronous reset mid-stream takes effect without a clock edge.
    #2;
    rstn = 1'b0;
    #1;
    reset_values("async reset");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    fork
      run_random(0, 1000);
      run_random(1, 1000);
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
